// File: rtl/memarb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memarb_pkg
// Brief    : Shared types and constants for the fetch/data memory port arbiter.
// Revision : 1.0
// ============================================================================
package memarb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } memarb_state_e;

    localparam logic [0:1] SIZE_BYTE = 2'b00;
    localparam logic [0:1] SIZE_HALF = 2'b01;
    localparam logic [0:1] SIZE_WORD = 2'b10;

    localparam memarb_state_e RST_STATE    = IDLE;
    localparam logic [0:1]    RST_MEM_SIZE = SIZE_WORD;
    localparam logic          RST_PULSE    = 1'b0;

endpackage
`default_nettype wire

// File: rtl/memarb_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : memarb_wait_counter
// Brief    : Saturating ack-wait counter; expired marks the MAX_WAIT-th cycle.
// Revision : 1.0
// ============================================================================
module memarb_wait_counter #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             CW     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0]  C_LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = (count_q == C_LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Serialises fetch and data requests onto one req/ack memory bus.
//            Optional ack timeout enabled by macro MEMARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter
    import memarb_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int MaxWait   = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_req,
    input  logic [0:AddrWidth-1] if_addr,
    output logic [0:DataWidth-1] if_rdata,
    output logic                 if_valid,
    input  logic                 dm_req,
    input  logic                 dm_we,
    input  logic [0:AddrWidth-1] dm_addr,
    input  logic [0:DataWidth-1] dm_wdata,
    input  logic [0:1]           dm_size,
    input  logic                 dm_ext,
    output logic [0:DataWidth-1] dm_rdata,
    output logic                 dm_valid,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [0:AddrWidth-1] mem_addr,
    output logic [0:DataWidth-1] mem_wdata,
    output logic [0:1]           mem_size,
    output logic                 mem_ext,
    input  logic                 mem_ack,
    input  logic [0:DataWidth-1] mem_rdata,
    output logic                 stall,
    output logic                 bus_err
);

    memarb_state_e        state_q, state_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [0:AddrWidth-1] mem_addr_q, mem_addr_d;
    logic [0:DataWidth-1] mem_wdata_q, mem_wdata_d;
    logic [0:1]           mem_size_q, mem_size_d;
    logic                 mem_ext_q, mem_ext_d;
    logic [0:DataWidth-1] if_rdata_q, if_rdata_d;
    logic [0:DataWidth-1] dm_rdata_q, dm_rdata_d;
    logic                 if_valid_q, if_valid_d;
    logic                 dm_valid_q, dm_valid_d;
    logic                 bus_err_q, bus_err_d;
    logic                 streak_q, streak_d;
    logic                 starve_q, starve_d;
    logic                 w_timeout;
    logic                 w_grant;
    logic                 w_bubble;

    // The completing requester still holds its req during its valid cycle,
    // so no grant may be issued then or the same access would repeat.
    assign w_bubble = if_valid_q | dm_valid_q;
    assign w_grant  = (state_q == IDLE) && (state_d != IDLE);

`ifdef MEMARB_TIMEOUT_EN
    logic w_expired;

    memarb_wait_counter #(
        .MAX_WAIT (MaxWait)
    ) u_wait_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_grant),
        .enable  (state_q != IDLE),
        .expired (w_expired)
    );

    assign w_timeout = w_expired & ~mem_ack;
    assign bus_err   = bus_err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{MaxWait, w_grant, bus_err_q};
    assign w_timeout  = 1'b0;
    assign bus_err    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;
        mem_ext_d   = mem_ext_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        bus_err_d   = 1'b0;
        streak_d    = streak_q;
        starve_d    = starve_q;

        case (state_q)
            IDLE: begin
                if (!w_bubble) begin
                    if (if_req && (starve_q || !dm_req)) begin
                        state_d    = FETCH;
                        mem_we_d   = 1'b0;
                        mem_addr_d = if_addr;
                        mem_size_d = SIZE_WORD;
                        mem_ext_d  = 1'b0;
                        starve_d   = 1'b0;
                        streak_d   = 1'b0;
                    end else if (dm_req) begin
                        state_d     = DATA;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        mem_size_d  = dm_size;
                        mem_ext_d   = dm_ext;
                        // Second consecutive data grant over a waiting fetch
                        // hands the next grant to fetch.
                        if (if_req) begin
                            starve_d = streak_q;
                            streak_d = ~streak_q;
                        end else begin
                            streak_d = 1'b0;
                        end
                    end
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    if_rdata_d = mem_rdata;
                    if_valid_d = 1'b1;
                    state_d    = IDLE;
                end else if (w_timeout) begin
                    if_rdata_d = '0;
                    if_valid_d = 1'b1;
                    bus_err_d  = 1'b1;
                    state_d    = IDLE;
                end
            end
            DATA: begin
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                    dm_valid_d = 1'b1;
                    state_d    = IDLE;
                end else if (w_timeout) begin
                    dm_rdata_d = '0;
                    dm_valid_d = 1'b1;
                    bus_err_d  = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_req_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RST_STATE;
            mem_req_q   <= RST_PULSE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= RST_MEM_SIZE;
            mem_ext_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= RST_PULSE;
            dm_valid_q  <= RST_PULSE;
            bus_err_q   <= RST_PULSE;
            streak_q    <= 1'b0;
            starve_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
            mem_ext_q   <= mem_ext_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            bus_err_q   <= bus_err_d;
            streak_q    <= streak_d;
            starve_q    <= starve_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_size  = mem_size_q;
    assign mem_ext   = mem_ext_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign stall     = (if_req & ~if_valid_q) | (dm_req & ~dm_valid_q);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [0:31] if_addr;
    logic [0:31] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [0:31] dm_addr;
    logic [0:31] dm_wdata;
    logic [0:1]  dm_size;
    logic        dm_ext;
    logic [0:31] dm_rdata;
    logic        dm_valid;
    logic        mem_req;
    logic        mem_we;
    logic [0:31] mem_addr;
    logic [0:31] mem_wdata;
    logic [0:1]  mem_size;
    logic        mem_ext;
    logic        mem_ack;
    logic [0:31] mem_rdata;
    logic        stall;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AddrWidth (32),
        .DataWidth (32),
        .MaxWait   (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_size   (dm_size),
        .dm_ext    (dm_ext),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_size  (mem_size),
        .mem_ext   (mem_ext),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .bus_err   (bus_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        dm_size   = 2'b10;
        dm_ext    = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        // Reset state
        tick;
        tick;
        check("rst_mem_req",  32'(mem_req),  32'h0);
        check("rst_if_valid", 32'(if_valid), 32'h0);
        check("rst_dm_valid", 32'(dm_valid), 32'h0);
        check("rst_mem_size", 32'(mem_size), 32'h2);
        check("rst_if_rdata", if_rdata,      32'h0);
        check("rst_dm_rdata", dm_rdata,      32'h0);
        check("rst_mem_addr", mem_addr,      32'h0);
        check("rst_bus_err",  32'(bus_err),  32'h0);
        reset = 1'b0;
        tick;

        // Fetch only
        if_req  = 1'b1;
        if_addr = 32'h100;
        #1;
        check("f_stall_pre", 32'(stall), 32'h1);
        tick;
        check("f_mem_req",  32'(mem_req),  32'h1);
        check("f_mem_addr", mem_addr,      32'h100);
        check("f_mem_we",   32'(mem_we),   32'h0);
        check("f_mem_size", 32'(mem_size), 32'h2);
        check("f_stall_1",  32'(stall),    32'h1);
        check("f_no_valid", 32'(if_valid), 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h20010004;
        tick;
        mem_ack = 1'b0;
        check("f_if_valid", 32'(if_valid), 32'h1);
        check("f_if_rdata", if_rdata,      32'h20010004);
        check("f_req_drop", 32'(mem_req),  32'h0);
        check("f_stall_lo", 32'(stall),    32'h0);
        if_req = 1'b0;
        tick;
        check("f_pulse_end", 32'(if_valid), 32'h0);

        // Simultaneous fetch and load: data first
        if_req  = 1'b1;
        if_addr = 32'h104;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h40;
        dm_size = 2'b10;
        tick;
        check("s_data_addr", mem_addr,    32'h40);
        check("s_data_we",   32'(mem_we), 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF0001;
        tick;
        mem_ack = 1'b0;
        check("s_dm_valid",  32'(dm_valid), 32'h1);
        check("s_dm_rdata",  dm_rdata,      32'hFFFF0001);
        check("s_if_wait",   32'(if_valid), 32'h0);
        check("s_stall_if",  32'(stall),    32'h1);
        dm_req = 1'b0;
        tick;
        check("s_bubble",    32'(mem_req),  32'h0);
        tick;
        check("s_fetch_req", 32'(mem_req),  32'h1);
        check("s_fetch_adr", mem_addr,      32'h104);
        mem_ack   = 1'b1;
        mem_rdata = 32'h00000013;
        tick;
        mem_ack = 1'b0;
        check("s_if_rdata",  if_rdata,      32'h00000013);
        if_req = 1'b0;
        tick;

        // Byte store: dm_rdata must hold the previous load data
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h43;
        dm_wdata = 32'hA5;
        dm_size  = 2'b00;
        tick;
        check("w_mem_we",    32'(mem_we),   32'h1);
        check("w_mem_size",  32'(mem_size), 32'h0);
        check("w_mem_wdata", mem_wdata,     32'hA5);
        check("w_mem_addr",  mem_addr,      32'h43);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick;
        mem_ack = 1'b0;
        check("w_dm_valid",  32'(dm_valid), 32'h1);
        check("w_dm_rdata",  dm_rdata,      32'hFFFF0001);
        dm_req = 1'b0;
        dm_we  = 1'b0;
        tick;

        // Anti-starvation: third grant goes to fetch
        if_req  = 1'b1;
        if_addr = 32'h200;
        dm_req  = 1'b1;
        dm_addr = 32'h80;
        dm_size = 2'b10;
        tick;
        check("a_g1_addr", mem_addr, 32'h80);
        mem_ack   = 1'b1;
        mem_rdata = 32'h11111111;
        tick;
        mem_ack = 1'b0;
        check("a_g1_valid", 32'(dm_valid), 32'h1);
        dm_addr = 32'h84;
        tick;
        tick;
        check("a_g2_addr", mem_addr, 32'h84);
        mem_ack   = 1'b1;
        mem_rdata = 32'h22222222;
        tick;
        mem_ack = 1'b0;
        dm_addr = 32'h88;
        tick;
        tick;
        check("a_g3_fetch", mem_addr,    32'h200);
        check("a_g3_we",    32'(mem_we), 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h33333333;
        tick;
        mem_ack = 1'b0;
        check("a_g3_valid", 32'(if_valid), 32'h1);
        check("a_g3_rdata", if_rdata,      32'h33333333);
        if_addr = 32'h204;
        tick;
        tick;
        check("a_g4_data", mem_addr, 32'h88);
        mem_ack   = 1'b1;
        mem_rdata = 32'h44444444;
        tick;
        mem_ack = 1'b0;
        check("a_g4_rdata", dm_rdata, 32'h44444444);
        if_req = 1'b0;
        dm_req = 1'b0;
        tick;

        // Reset during an access
        if_req  = 1'b1;
        if_addr = 32'h300;
        tick;
        check("r_granted", 32'(mem_req), 32'h1);
        tick;
        reset = 1'b1;
        #1;
        check("r_req_drop", 32'(mem_req), 32'h0);
        if_req    = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h55555555;
        tick;
        reset = 1'b0;
        tick;
        mem_ack = 1'b0;
        check("r_no_valid", 32'(if_valid), 32'h0);
        check("r_idle",     32'(mem_req),  32'h0);
        check("r_rdata",    if_rdata,      32'h0);
        tick;

`ifdef MEMARB_TIMEOUT_EN
        // Ack timeout, then normal service
        if_req  = 1'b1;
        if_addr = 32'h400;
        tick;
        repeat (14) tick;
        check("t_still_wait", 32'(mem_req), 32'h1);
        check("t_no_err",     32'(bus_err), 32'h0);
        tick;
        check("t_bus_err",  32'(bus_err),  32'h1);
        check("t_if_valid", 32'(if_valid), 32'h1);
        check("t_if_rdata", if_rdata,      32'h0);
        check("t_req_drop", 32'(mem_req),  32'h0);
        if_addr = 32'h404;
        tick;
        check("t_err_pulse", 32'(bus_err), 32'h0);
        tick;
        check("t_regrant", mem_addr, 32'h404);
        mem_ack   = 1'b1;
        mem_rdata = 32'h66666666;
        tick;
        mem_ack = 1'b0;
        check("t_ok_rdata", if_rdata, 32'h66666666);
        if_req = 1'b0;
        tick;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
